controle_epocas: RTL

- Training-loop controller directly downstream of the epoch stage.
- Issues one epoch request at a time, carrying the current FP16 weights w0..w2.
- Consumes the epoch's 4 activation outputs and its updated weights.
- Counts misclassified samples, repeats epochs until zero errors or MAX_EPOCAS, then reports final weights and a convergence flag.

---
 rtl/controle_epocas.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/controle_epocas.sv
// Training-loop controller: issues epoch requests, counts misclassified samples and
// repeats until zero errors or MAX_EPOCAS. Optional macro CONTROLE_NAN_CHECK_EN adds erro_nan.
module controle_epocas #(
    parameter int TAM        = 16,
    parameter int N_AMOSTRAS = 4,
    parameter int MAX_EPOCAS = 15,
    parameter int CNT_W      = 8,
    localparam int EW        = $clog2(N_AMOSTRAS + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [TAM-1:0]            w_init0,
    input  logic [TAM-1:0]            w_init1,
    input  logic [TAM-1:0]            w_init2,
    input  logic [N_AMOSTRAS*TAM-1:0] d,
    output logic                      ep_start,
    output logic [TAM-1:0]            ep_w0,
    output logic [TAM-1:0]            ep_w1,
    output logic [TAM-1:0]            ep_w2,
    input  logic                      ep_valid,
    input  logic [N_AMOSTRAS*TAM-1:0] ep_result,
    input  logic [TAM-1:0]            ep_w0_new,
    input  logic [TAM-1:0]            ep_w1_new,
    input  logic [TAM-1:0]            ep_w2_new,
    output logic                      busy,
    output logic                      done,
    output logic                      convergiu,
    output logic [CNT_W-1:0]          epoca,
    output logic [EW-1:0]             erros,
    output logic [TAM-1:0]            w0,
    output logic [TAM-1:0]            w1,
    output logic [TAM-1:0]            w2
`ifdef CONTROLE_NAN_CHECK_EN
    ,
    output logic                      erro_nan
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_WAIT, S_EVAL, S_DONE} estado_t;

    // A zero epoch limit still runs one epoch
    localparam int MAX_EF = (MAX_EPOCAS < 1) ? 1 : MAX_EPOCAS;

    estado_t                   state_q, state_d;
    logic [TAM-1:0]            w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
    logic [N_AMOSTRAS*TAM-1:0] res_q, res_d;
    logic [CNT_W-1:0]          epoca_q, epoca_d;
    logic [EW-1:0]             erros_q, erros_d;
    logic                      conv_q, conv_d;
    logic                      ep_start_q, ep_start_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      nan_q, nan_d;
    logic [EW-1:0]             cnt_s;
    logic                      forcar_fim_s;

    // +0 and -0 compare equal; everything else compares bitwise
    function automatic logic amostra_igual(input logic [TAM-1:0] a, input logic [TAM-1:0] b);
        return (a == b) || ((a[TAM-2:0] == {(TAM-1){1'b0}}) && (b[TAM-2:0] == {(TAM-1){1'b0}}));
    endfunction

    function automatic logic [EW-1:0] conta_erros(input logic [N_AMOSTRAS*TAM-1:0] r,
                                                  input logic [N_AMOSTRAS*TAM-1:0] dd);
        logic [EW-1:0] n;
        n = '0;
        for (int i = 0; i < N_AMOSTRAS; i++) begin
            if (!amostra_igual(r[i*TAM +: TAM], dd[i*TAM +: TAM])) begin
                n = n + EW'(1);
            end
        end
        return n;
    endfunction

    function automatic logic nao_finito(input logic [TAM-1:0] x);
        return &x[TAM-2 -: 5];
    endfunction

    assign cnt_s = conta_erros(res_q, d);
`ifdef CONTROLE_NAN_CHECK_EN
    assign forcar_fim_s = nan_q;
`else
    assign forcar_fim_s = 1'b0;
`endif

    // Next-state and next-register computation
    always_comb begin
        state_d = state_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        res_d   = res_q;
        epoca_d = epoca_q;
        erros_d = erros_q;
        conv_d  = conv_q;
        nan_d   = nan_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w0_d    = w_init0;
                    w1_d    = w_init1;
                    w2_d    = w_init2;
                    epoca_d = '0;
                    erros_d = '0;
                    conv_d  = 1'b0;
                    nan_d   = 1'b0;
                    state_d = S_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN: state_d = S_WAIT;
            S_WAIT: begin
                if (ep_valid) begin
                    w0_d    = ep_w0_new;
                    w1_d    = ep_w1_new;
                    w2_d    = ep_w2_new;
                    res_d   = ep_result;
                    epoca_d = epoca_q + CNT_W'(1);
                    nan_d   = nan_q | nao_finito(ep_w0_new) | nao_finito(ep_w1_new)
                                    | nao_finito(ep_w2_new);
                    state_d = S_EVAL;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_EVAL: begin
                erros_d = cnt_s;
                if (forcar_fim_s) begin
                    conv_d  = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_s == '0) begin
                    conv_d  = 1'b1;
                    state_d = S_DONE;
                end else if (epoca_q >= CNT_W'(MAX_EF)) begin
                    conv_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ep_start_d = (state_d == S_RUN);
        busy_d     = (state_d == S_RUN) || (state_d == S_WAIT) || (state_d == S_EVAL);
        done_d     = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            w0_q       <= '0;
            w1_q       <= '0;
            w2_q       <= '0;
            res_q      <= '0;
            epoca_q    <= '0;
            erros_q    <= '0;
            conv_q     <= 1'b0;
            nan_q      <= 1'b0;
            ep_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            w0_q       <= w0_d;
            w1_q       <= w1_d;
            w2_q       <= w2_d;
            res_q      <= res_d;
            epoca_q    <= epoca_d;
            erros_q    <= erros_d;
            conv_q     <= conv_d;
            nan_q      <= nan_d;
            ep_start_q <= ep_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ep_start  = ep_start_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign convergiu = conv_q;
    assign epoca     = epoca_q;
    assign erros     = erros_q;
    assign w0        = w0_q;
    assign w1        = w1_q;
    assign w2        = w2_q;
    assign ep_w0     = w0_q;
    assign ep_w1     = w1_q;
    assign ep_w2     = w2_q;
`ifdef CONTROLE_NAN_CHECK_EN
    assign erro_nan  = nan_q;
`endif

endmodule
